// File: rtl/encode_prefix_emitter_if.sv
// Request and byte-stream bundle for encode_prefix_emitter.
// The emitter takes the slave view; the requester/downstream side takes the master view.
interface encode_prefix_emitter_if;
    logic       i_req_valid;
    logic       o_req_ready;
    logic       i_lock_bus;
    logic       i_repeat_not_equal;
    logic       i_repeat_equal;
    logic       i_segment_override;
    logic [2:0] i_segment_override_index;
    logic       i_hint_branch_not_taken;
    logic       i_hint_branch_taken;
    logic       i_operand_size;
    logic       i_address_size;
    logic       o_byte_valid;
    logic       i_byte_ready;
    logic [7:0] o_byte;
    logic       o_byte_last;
    logic       o_done;
    logic       o_error;
    logic [2:0] o_bytes_emitted;

    modport slave (
        input  i_req_valid,
        output o_req_ready,
        input  i_lock_bus,
        input  i_repeat_not_equal,
        input  i_repeat_equal,
        input  i_segment_override,
        input  i_segment_override_index,
        input  i_hint_branch_not_taken,
        input  i_hint_branch_taken,
        input  i_operand_size,
        input  i_address_size,
        output o_byte_valid,
        input  i_byte_ready,
        output o_byte,
        output o_byte_last,
        output o_done,
        output o_error,
        output o_bytes_emitted
    );

    modport master (
        output i_req_valid,
        input  o_req_ready,
        output i_lock_bus,
        output i_repeat_not_equal,
        output i_repeat_equal,
        output i_segment_override,
        output i_segment_override_index,
        output i_hint_branch_not_taken,
        output i_hint_branch_taken,
        output i_operand_size,
        output i_address_size,
        input  o_byte_valid,
        output i_byte_ready,
        input  o_byte,
        input  o_byte_last,
        input  o_done,
        input  o_error,
        input  o_bytes_emitted
    );
endinterface

// File: rtl/encode_prefix_emitter.sv
// Serialises a prefix request into legacy x86 prefix bytes (group1, group2, group3, group4 order).
// Define PREFIX_EMIT_BRANCH_HINT_EN to let the branch-hint inputs fill the group-2 slot (2E/3E).
module encode_prefix_emitter #(
    parameter int PREFIX_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    encode_prefix_emitter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EMIT   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [2:0] LIMIT = 3'(PREFIX_LIMIT);

    state_t     state_q, state_d;
    logic [7:0] buf_q [4];
    logic [7:0] buf_d [4];
    logic [2:0] total_q, total_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] byte_q, byte_d;
    logic       last_q, last_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic [2:0] emitted_q, emitted_d;

    logic       hint_nt_w;
    logic       hint_t_w;
    logic [1:0] g1_cnt_w;
    logic [1:0] g2_cnt_w;
    logic [7:0] g1_byte_w;
    logic [7:0] g2_byte_w;
    logic [7:0] seg_byte_w;
    logic       seg_bad_w;
    logic       conflict_w;
    logic [7:0] pack_w [4];
    logic [2:0] n_w;
    logic [2:0] nxt_w;

`ifdef PREFIX_EMIT_BRANCH_HINT_EN
    assign hint_nt_w = bus.i_hint_branch_not_taken;
    assign hint_t_w  = bus.i_hint_branch_taken;
`else
    logic unused_hints;
    assign unused_hints = bus.i_hint_branch_not_taken ^ bus.i_hint_branch_taken;
    assign hint_nt_w    = 1'b0;
    assign hint_t_w     = 1'b0;
`endif

    always_comb begin
        seg_byte_w = 8'h00;
        case (bus.i_segment_override_index)
            3'd0:    seg_byte_w = 8'h26;
            3'd1:    seg_byte_w = 8'h2E;
            3'd2:    seg_byte_w = 8'h36;
            3'd3:    seg_byte_w = 8'h3E;
            3'd4:    seg_byte_w = 8'h64;
            3'd5:    seg_byte_w = 8'h65;
            default: seg_byte_w = 8'h00;
        endcase
    end

    assign g1_cnt_w = {1'b0, bus.i_lock_bus} + {1'b0, bus.i_repeat_not_equal}
                    + {1'b0, bus.i_repeat_equal};
    assign g2_cnt_w = {1'b0, bus.i_segment_override} + {1'b0, hint_nt_w} + {1'b0, hint_t_w};

    // Priority only matters for conflicting requests, whose bytes are never emitted.
    assign g1_byte_w = bus.i_lock_bus ? 8'hF0 : (bus.i_repeat_not_equal ? 8'hF2 : 8'hF3);
    assign g2_byte_w = bus.i_segment_override ? seg_byte_w : (hint_nt_w ? 8'h2E : 8'h3E);

    assign seg_bad_w = bus.i_segment_override && (bus.i_segment_override_index > 3'd5);

    // Compact the present groups into consecutive slots so absent groups cost no cycle.
    always_comb begin
        logic [2:0] slot;
        for (int k = 0; k < 4; k++) begin
            pack_w[k] = 8'h00;
        end
        slot = 3'd0;
        if (g1_cnt_w != 2'd0) begin
            pack_w[slot[1:0]] = g1_byte_w;
            slot = slot + 3'd1;
        end
        if (g2_cnt_w != 2'd0) begin
            pack_w[slot[1:0]] = g2_byte_w;
            slot = slot + 3'd1;
        end
        if (bus.i_operand_size) begin
            pack_w[slot[1:0]] = 8'h66;
            slot = slot + 3'd1;
        end
        if (bus.i_address_size) begin
            pack_w[slot[1:0]] = 8'h67;
            slot = slot + 3'd1;
        end
        n_w = slot;
    end

    assign conflict_w = (g1_cnt_w > 2'd1) || seg_bad_w || (g2_cnt_w > 2'd1) || (n_w > LIMIT);

    assign nxt_w = cnt_q + 3'd1;

    always_comb begin
        state_d   = state_q;
        total_d   = total_q;
        cnt_d     = cnt_q;
        byte_d    = byte_q;
        last_d    = last_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        emitted_d = 3'd0;
        for (int k = 0; k < 4; k++) begin
            buf_d[k] = buf_q[k];
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req_valid) begin
                    for (int k = 0; k < 4; k++) begin
                        buf_d[k] = pack_w[k];
                    end
                    total_d = n_w;
                    cnt_d   = 3'd0;
                    if (conflict_w) begin
                        state_d = ST_FINISH;
                        error_d = 1'b1;
                    end else if (n_w == 3'd0) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_EMIT;
                        byte_d  = pack_w[0];
                        last_d  = (n_w == 3'd1);
                    end
                end
            end
            ST_EMIT: begin
                if (bus.i_byte_ready) begin
                    cnt_d = nxt_w;
                    if (last_q) begin
                        state_d   = ST_FINISH;
                        done_d    = 1'b1;
                        emitted_d = nxt_w;
                        last_d    = 1'b0;
                    end else begin
                        byte_d = buf_q[nxt_w[1:0]];
                        last_d = ((nxt_w + 3'd1) == total_q);
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            total_q   <= 3'd0;
            cnt_q     <= 3'd0;
            byte_q    <= 8'h00;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            emitted_q <= 3'd0;
            for (int k = 0; k < 4; k++) begin
                buf_q[k] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            total_q   <= total_d;
            cnt_q     <= cnt_d;
            byte_q    <= byte_d;
            last_q    <= last_d;
            done_q    <= done_d;
            error_q   <= error_d;
            emitted_q <= emitted_d;
            for (int k = 0; k < 4; k++) begin
                buf_q[k] <= buf_d[k];
            end
        end
    end

    assign bus.o_req_ready     = (state_q == ST_IDLE);
    assign bus.o_byte_valid    = (state_q == ST_EMIT);
    assign bus.o_byte          = byte_q;
    assign bus.o_byte_last     = last_q;
    assign bus.o_done          = done_q;
    assign bus.o_error         = error_q;
    assign bus.o_bytes_emitted = emitted_q;
endmodule

// File: tb/tb_encode_prefix_emitter.sv
// Directed, table-driven bench for encode_prefix_emitter, plus reset and decoder-loopback sequences.
module tb_encode_prefix_emitter;
    typedef struct packed {
        logic       lock;
        logic       rne;
        logic       re;
        logic       seg;
        logic [2:0] idx;
        logic       hnt;
        logic       ht;
        logic       op;
        logic       ad;
    } req_t;

    typedef struct {
        req_t        req;
        bit          lim2;
        int          stall;
        bit          exp_err;
        int          exp_n;
        logic [31:0] exp_bytes;
    } vec_t;

    typedef struct {
        bit          ready_at_accept;
        logic [31:0] bytes;
        int          n;
        logic [3:0]  last_mask;
        int          done_cnt;
        int          err_cnt;
        logic [2:0]  emitted;
        int          ready_cycle;
        bit          unstable;
        bit          overlap;
    } res_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic sel = 1'b0;
    logic req_valid = 1'b0;
    logic byte_ready = 1'b1;
    req_t cur = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    encode_prefix_emitter_if bus ();
    encode_prefix_emitter_if bus2 ();

    assign bus.i_req_valid               = req_valid & ~sel;
    assign bus2.i_req_valid              = req_valid & sel;
    assign bus.i_lock_bus                = cur.lock;
    assign bus2.i_lock_bus               = cur.lock;
    assign bus.i_repeat_not_equal        = cur.rne;
    assign bus2.i_repeat_not_equal       = cur.rne;
    assign bus.i_repeat_equal            = cur.re;
    assign bus2.i_repeat_equal           = cur.re;
    assign bus.i_segment_override        = cur.seg;
    assign bus2.i_segment_override       = cur.seg;
    assign bus.i_segment_override_index  = cur.idx;
    assign bus2.i_segment_override_index = cur.idx;
    assign bus.i_hint_branch_not_taken   = cur.hnt;
    assign bus2.i_hint_branch_not_taken  = cur.hnt;
    assign bus.i_hint_branch_taken       = cur.ht;
    assign bus2.i_hint_branch_taken      = cur.ht;
    assign bus.i_operand_size            = cur.op;
    assign bus2.i_operand_size           = cur.op;
    assign bus.i_address_size            = cur.ad;
    assign bus2.i_address_size           = cur.ad;
    assign bus.i_byte_ready              = byte_ready;
    assign bus2.i_byte_ready             = byte_ready;

    encode_prefix_emitter #(.PREFIX_LIMIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    encode_prefix_emitter #(.PREFIX_LIMIT(2)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    logic       obs_ready, obs_valid, obs_last, obs_done, obs_error;
    logic [7:0] obs_byte;
    logic [2:0] obs_emitted;
    assign obs_ready   = sel ? bus2.o_req_ready     : bus.o_req_ready;
    assign obs_valid   = sel ? bus2.o_byte_valid    : bus.o_byte_valid;
    assign obs_last    = sel ? bus2.o_byte_last     : bus.o_byte_last;
    assign obs_done    = sel ? bus2.o_done          : bus.o_done;
    assign obs_error   = sel ? bus2.o_error         : bus.o_error;
    assign obs_byte    = sel ? bus2.o_byte          : bus.o_byte;
    assign obs_emitted = sel ? bus2.o_bytes_emitted : bus.o_bytes_emitted;

    function automatic req_t mk(input bit lock, input bit rne, input bit re, input bit seg,
                                input int idx, input bit hnt, input bit ht, input bit op,
                                input bit ad);
        req_t r;
        r.lock = lock; r.rne = rne; r.re = re; r.seg = seg; r.idx = 3'(idx);
        r.hnt = hnt; r.ht = ht; r.op = op; r.ad = ad;
        return r;
    endfunction

    function automatic vec_t mkv(input req_t r, input bit lim2, input int stall,
                                 input bit err, input int n, input logic [31:0] bytes);
        vec_t v;
        v.req = r; v.lim2 = lim2; v.stall = stall;
        v.exp_err = err; v.exp_n = n; v.exp_bytes = bytes;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] out_snapshot();
        return {obs_ready, obs_valid, obs_last, obs_done, obs_error, obs_emitted, obs_byte};
    endfunction

    // Reference decoder: consumes leading prefix bytes of a 4-byte window.
    task automatic decode_window(input logic [31:0] win, output req_t flags,
                                 output int consumed, output bit err);
        bit g1, g2, g3, g4, stop;
        logic [7:0] b;
        flags = '0; consumed = 0; err = 0;
        g1 = 0; g2 = 0; g3 = 0; g4 = 0; stop = 0;
        for (int k = 0; k < 4; k++) begin
            b = win[8*k +: 8];
            if (!stop) begin
                case (b)
                    8'hF0, 8'hF2, 8'hF3: begin
                        if (g1) err = 1;
                        g1 = 1;
                        if (b == 8'hF0) flags.lock = 1;
                        else if (b == 8'hF2) flags.rne = 1;
                        else flags.re = 1;
                    end
                    8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: begin
                        if (g2) err = 1;
                        g2 = 1;
                        flags.seg = 1;
                        case (b)
                            8'h26:   flags.idx = 3'd0;
                            8'h2E:   flags.idx = 3'd1;
                            8'h36:   flags.idx = 3'd2;
                            8'h3E:   flags.idx = 3'd3;
                            8'h64:   flags.idx = 3'd4;
                            default: flags.idx = 3'd5;
                        endcase
                    end
                    8'h66: begin
                        if (g3) err = 1;
                        g3 = 1; flags.op = 1;
                    end
                    8'h67: begin
                        if (g4) err = 1;
                        g4 = 1; flags.ad = 1;
                    end
                    default: stop = 1;
                endcase
                if (!stop) consumed++;
            end
        end
    endtask

    task automatic run_req(input req_t r, input bit use2, input int stall, output res_t res);
        bit         have_prev;
        bit         prev_xfer;
        logic [7:0] prev_byte;
        res.ready_at_accept = 0; res.bytes = '0; res.n = 0; res.last_mask = '0;
        res.done_cnt = 0; res.err_cnt = 0; res.emitted = '0; res.ready_cycle = 0;
        res.unstable = 0; res.overlap = 0;
        have_prev = 0; prev_xfer = 1; prev_byte = 8'h00;

        @(negedge clock);
        sel = use2;
        cur = r;
        req_valid = 1'b1;
        byte_ready = (stall == 0);
        #1 res.ready_at_accept = obs_ready;
        @(negedge clock);
        req_valid = 1'b0;
        cur = req_t'($urandom);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (obs_valid && (obs_done || obs_error)) res.overlap = 1;
            if (have_prev && !prev_xfer && (!obs_valid || obs_byte !== prev_byte))
                res.unstable = 1;
            if (obs_done) begin
                res.done_cnt++;
                res.emitted = obs_emitted;
            end
            if (obs_error) begin
                res.err_cnt++;
                res.emitted = obs_emitted;
            end
            if (obs_ready) begin
                res.ready_cycle = cyc;
                break;
            end
            byte_ready = (cyc > stall);
            if (obs_valid) begin
                if (byte_ready && res.n < 4) begin
                    res.bytes[8*res.n +: 8] = obs_byte;
                    res.last_mask[res.n] = obs_last;
                end
                if (byte_ready) res.n++;
                prev_byte = obs_byte;
                have_prev = 1;
                prev_xfer = byte_ready;
            end else begin
                have_prev = 0;
            end
            @(negedge clock);
        end
        byte_ready = 1'b1;
        cur = '0;
    endtask

    task automatic check_res(input int id, input vec_t v, input res_t res);
        int exp_n;
        exp_n = v.exp_err ? 0 : v.exp_n;
        chk($sformatf("v%0d accept_ready", id), 32'(res.ready_at_accept), 32'd1);
        chk($sformatf("v%0d bytes", id), res.bytes, v.exp_bytes);
        chk($sformatf("v%0d byte_count", id), 32'(res.n), 32'(exp_n));
        chk($sformatf("v%0d pulses", id), 32'(res.done_cnt * 16 + res.err_cnt),
            v.exp_err ? 32'd1 : 32'd16);
        chk($sformatf("v%0d bytes_emitted", id), 32'(res.emitted), 32'(exp_n));
        chk($sformatf("v%0d last_flag", id), 32'(res.last_mask),
            (exp_n > 0) ? (32'd1 << (exp_n - 1)) : 32'd0);
        chk($sformatf("v%0d stable_no_overlap", id), 32'({res.unstable, res.overlap}), 32'd0);
        chk($sformatf("v%0d ready_latency", id), 32'(res.ready_cycle),
            (v.exp_err || exp_n == 0) ? 32'd2 : 32'(exp_n + 2 + v.stall));
    endtask

    vec_t vecs [18];
    res_t res;

    initial begin
        //                 lock rne re seg idx hnt ht op ad     lim2 stall err n bytes
        vecs[0]  = mkv(mk(1,0,0,1,4,0,0,1,1), 0, 0, 0, 4, 32'h676664F0);
        vecs[1]  = mkv(mk(0,0,1,0,0,0,0,0,0), 0, 3, 0, 1, 32'h000000F3);
        vecs[2]  = mkv(mk(0,1,1,0,0,0,0,0,0), 0, 0, 1, 0, 32'h00000000);
        vecs[3]  = mkv(mk(0,0,0,0,0,0,0,0,0), 0, 0, 0, 0, 32'h00000000);
        vecs[4]  = mkv(mk(0,0,0,1,7,0,0,0,0), 0, 0, 1, 0, 32'h00000000);
        vecs[5]  = mkv(mk(0,1,0,1,2,0,0,0,1), 0, 0, 0, 3, 32'h006736F2);
        vecs[6]  = mkv(mk(0,0,0,0,0,0,0,1,0), 0, 0, 0, 1, 32'h00000066);
        vecs[7]  = mkv(mk(0,0,0,1,5,0,0,0,0), 0, 0, 0, 1, 32'h00000065);
        vecs[8]  = mkv(mk(0,0,0,1,0,0,0,1,0), 0, 0, 0, 2, 32'h00006626);
        vecs[9]  = mkv(mk(0,0,0,1,1,0,0,0,1), 0, 2, 0, 2, 32'h0000672E);
        vecs[10] = mkv(mk(1,1,0,0,0,0,0,0,0), 0, 0, 1, 0, 32'h00000000);
        vecs[11] = mkv(mk(1,0,0,0,0,0,0,1,1), 1, 0, 1, 0, 32'h00000000);
        vecs[12] = mkv(mk(1,0,0,0,0,0,0,1,0), 1, 0, 0, 2, 32'h000066F0);
`ifdef PREFIX_EMIT_BRANCH_HINT_EN
        vecs[13] = mkv(mk(0,0,0,1,3,0,1,0,0), 0, 0, 1, 0, 32'h00000000);
        vecs[14] = mkv(mk(0,0,0,0,0,0,1,0,0), 0, 0, 0, 1, 32'h0000003E);
        vecs[15] = mkv(mk(0,0,0,0,0,1,0,0,1), 0, 0, 0, 2, 32'h0000672E);
`else
        vecs[13] = mkv(mk(0,0,0,1,3,0,1,0,0), 0, 0, 0, 1, 32'h0000003E);
        vecs[14] = mkv(mk(0,0,0,0,0,0,1,0,0), 0, 0, 0, 0, 32'h00000000);
        vecs[15] = mkv(mk(0,0,0,0,0,1,0,0,1), 0, 0, 0, 1, 32'h00000067);
`endif
        vecs[16] = mkv(mk(0,0,1,1,3,0,0,1,1), 0, 1, 0, 4, 32'h67663EF3);
        vecs[17] = mkv(mk(1,0,0,1,0,0,0,0,0), 1, 0, 0, 2, 32'h000026F0);

        #3;
        chk("reset_state_async", 32'(out_snapshot()), 32'h8000);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset_state_idle", 32'(out_snapshot()), 32'h8000);
        sel = 1'b1;
        #1 chk("reset_state_dut2", 32'(out_snapshot()), 32'h8000);
        sel = 1'b0;

        for (int i = 0; i < 18; i++) begin
            run_req(vecs[i].req, vecs[i].lim2, vecs[i].stall, res);
            $display("txn v%0d: req=%h bytes=%h n=%0d done=%0d err=%0d emitted=%0d ready_cyc=%0d",
                     i, vecs[i].req, res.bytes, res.n, res.done_cnt, res.err_cnt,
                     res.emitted, res.ready_cycle);
            check_res(i, vecs[i], res);
        end

        // Reset in the middle of emission, after two bytes have transferred.
        @(negedge clock);
        sel = 1'b0;
        cur = mk(1,0,0,1,4,0,0,1,1);
        req_valid = 1'b1;
        byte_ready = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        chk("rst_mid byte1", 32'(obs_byte), 32'h000000F0);
        @(negedge clock);
        chk("rst_mid byte2", 32'(obs_byte), 32'h00000064);
        @(negedge clock);
        #2 reset = 1'b1;
        #1 chk("rst_mid outputs", 32'(out_snapshot()), 32'h8000);
        @(negedge clock);
        reset = 1'b0;
        cur = '0;
        begin
            int pulses;
            pulses = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clock);
                if (obs_done || obs_error || obs_valid) pulses++;
            end
            chk("rst_mid no_pulse", 32'(pulses), 32'd0);
        end
        $display("txn reset_mid: reset applied during emission");
        run_req(mk(0,1,0,0,0,0,0,1,0), 0, 0, res);
        $display("txn after_reset: bytes=%h n=%0d emitted=%0d", res.bytes, res.n, res.emitted);
        chk("rst_mid next_bytes", res.bytes, 32'h000066F2);
        chk("rst_mid next_count", 32'(res.emitted), 32'd2);

        // Loopback through the reference decoder with random legal requests.
        for (int t = 0; t < 8; t++) begin
            req_t        r;
            req_t        dec;
            int          consumed;
            bit          derr;
            int          g1;
            logic [31:0] win;
            r = '0;
            g1 = int'($urandom_range(0, 3));
            r.lock = (g1 == 1);
            r.rne  = (g1 == 2);
            r.re   = (g1 == 3);
            r.seg  = 1'($urandom_range(0, 1));
            r.idx  = r.seg ? 3'($urandom_range(0, 5)) : 3'd0;
            r.op   = 1'($urandom_range(0, 1));
            r.ad   = 1'($urandom_range(0, 1));
            run_req(r, 0, 0, res);
            win = 32'h90909090;
            for (int k = 0; k < 4; k++) begin
                if (k < res.n) win[8*k +: 8] = res.bytes[8*k +: 8];
            end
            decode_window(win, dec, consumed, derr);
            $display("txn loop%0d: req=%h window=%h consumed=%0d emitted=%0d",
                     t, r, win, consumed, res.emitted);
            chk($sformatf("loop%0d flags", t), 32'(dec), 32'(r));
            chk($sformatf("loop%0d consumed", t), 32'(consumed), 32'(res.emitted));
            chk($sformatf("loop%0d dec_err_done", t), 32'({derr, res.done_cnt[0]}), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/encode_prefix_emitter.md
Name: encode_prefix_emitter

Overview:
- Inverse of the prefix decode stage: converts a prefix request (flag set) into a serial stream of legacy x86 prefix bytes, one byte per clock, under valid/ready handshakes on both sides.
- Used by the instruction-stream generator and self-test loopback: its bytes feed the 4-byte window of the prefix decode stage.
- Emits a canonical order, rejects conflicting requests and reports the byte count for cross-check against the decoder's consumed-byte count.

Parameters:
- PREFIX_LIMIT, 4, max prefix bytes per request (1..4); a legal request needing more bytes is rejected with an error.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- i_req_valid  input  1  request valid
- o_req_ready  output  1  emitter idle, can accept request
- i_lock_bus  input  1  request F0
- i_repeat_not_equal  input  1  request F2
- i_repeat_equal  input  1  request F3
- i_segment_override  input  1  request segment override
- i_segment_override_index  input  3  0=ES(26) 1=CS(2E) 2=SS(36) 3=DS(3E) 4=FS(64) 5=GS(65)
- i_hint_branch_not_taken  input  1  request 2E hint (see Optional Feature)
- i_hint_branch_taken  input  1  request 3E hint (see Optional Feature)
- i_operand_size  input  1  request 66
- i_address_size  input  1  request 67
- o_byte_valid  output  1  o_byte holds a prefix byte
- i_byte_ready  input  1  downstream accepts byte
- o_byte  output  8  prefix byte
- o_byte_last  output  1  final byte of current request
- o_done  output  1  one-cycle pulse: request finished (including zero-byte requests)
- o_error  output  1  one-cycle pulse: request rejected, no bytes emitted
- o_bytes_emitted  output  3  byte count of the finished request, valid while o_done=1

Behaviour:
- Reset (async, any state): state=IDLE; o_req_ready=1; o_byte_valid=0; o_byte=8'h00; o_byte_last=0; o_done=0; o_error=0; o_bytes_emitted=0. A request or byte in flight is dropped, with no done/error pulse.
- States: IDLE, EMIT, FINISH.
- IDLE: o_req_ready=1. A request is accepted when i_req_valid and o_req_ready are both 1. On acceptance, all inputs are latched and the state machine evaluates the latched values:
  - Conflict: goes to FINISH with an error pulse pending.
  - Zero bytes needed: goes to FINISH with a done pulse pending and count 0.
  - Otherwise: goes to EMIT.
- Conflict rules (any one true means error):
  - more than one of lock / rep_ne / rep_e;
  - segment override with index greater than 5;
  - more than one group-2 source (segment override, not-taken hint, taken hint);
  - total byte count greater than PREFIX_LIMIT.
- Emission order is fixed: group1 (F0/F2/F3), group2 (segment byte or hint), group3 (66), group4 (67). Absent groups are skipped with no bubble cycle.
- EMIT:
  - o_byte_valid=1; o_byte and o_byte_last are registered and stable while i_byte_ready=0.
  - A byte transfers when o_byte_valid and i_byte_ready are both 1. The next byte is presented in the following cycle, so back-to-back transfer gives 1 byte per cycle.
  - An internal 3-bit counter increments per transfer.
  - Transfer of the last byte moves the state to FINISH.
- FINISH (exactly one cycle): o_req_ready=0; o_byte_valid=0. Exactly one of o_done or o_error is 1. o_bytes_emitted holds the counter value on done and 0 on error. Next state is IDLE.
- Latency:
  - acceptance to first o_byte_valid: 1 cycle;
  - N-byte request with ready held high: N+2 cycles from acceptance back to o_req_ready=1.
- o_req_ready is 0 in EMIT and FINISH; i_req_valid is ignored there and inputs may change freely.
- o_byte_valid never drops before its transfer completes.
- o_done/o_error never assert in the same cycle as o_byte_valid.

Optional Feature:
- Macro PREFIX_EMIT_BRANCH_HINT_EN.
- Defined: hint inputs encode 2E (not taken) / 3E (taken) in the group-2 slot and participate in group-2 conflict checks.
- Undefined: hint inputs are ignored entirely (treated as 0, never emitted, never cause error); group 2 is produced only by i_segment_override.

Test Plan:
- lock + segment index 4 + operand + address, i_byte_ready held 1 -> bytes F0,64,66,67 on 4 consecutive cycles; o_byte_last on 67; o_done with o_bytes_emitted=3'd4.
- rep_equal only, i_byte_ready low for 3 cycles -> F3 held stable with o_byte_valid=1 until ready; o_byte_last=1; o_done with count 1.
- rep_ne + rep_e -> no o_byte_valid; o_error pulse 1 cycle; o_bytes_emitted=0; o_req_ready back to 1 two cycles after acceptance.
- Empty request -> o_done with count 0, no bytes; segment index 7 -> o_error; PREFIX_LIMIT=2 with 3 prefixes requested -> o_error.
- Loopback: the 4 emitted bytes are loaded into the prefix decode stage window for random legal requests -> decoded flags equal the request, o_bytes_consumed equals o_bytes_emitted, decoder error=0.
- Reset asserted mid-EMIT after byte 2 -> outputs go to reset values immediately; no done/error pulse; next request is emitted from its first byte.
- With PREFIX_EMIT_BRANCH_HINT_EN: taken hint -> 3E; hint + segment override -> o_error. Without the macro: the same hint + segment override request -> segment byte only, o_done with count 1.
